aes_encrypt_core: RTL and testbench

Iterative AES block encryptor (FIPS-197 Cipher) for 128-, 192- and 256-bit keys, one round per clock. Counterpart of the iterative decryptor: consumes the same `allKeys` bus produced by `KeyExpansion #(Nk, Nr)` and returns the ciphertext that the decryptor maps back to plaintext. Adds the explicit start/busy/valid handshake and synchronous reset the decryptor lacks, so a controller can issue back-to-back blocks.

---
 rtl/aes_encrypt_core_if.sv | 25 ++
 rtl/aes_encrypt_core.sv | 168 ++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_core_if.sv
// Start/busy/valid handshake and data bus between a controller and aes_encrypt_core.
// The controller drives the master side; the core implements the slave side.
interface aes_encrypt_core_if;
    logic         start;
    logic [127:0] data;
    logic [127:0] out;
    logic         valid;
    logic         busy;

    modport master (
        output start,
        output data,
        input  out,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  data,
        output out,
        output valid,
        output busy
    );
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES encryptor, one round per clock, for 128/192/256-bit keys.
// The expanded key schedule is read combinationally and must stay stable while busy.
module aes_encrypt_core #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [(Nr+1)*128-1:0] allKeys,
    aes_encrypt_core_if.slave     bus
);

    if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14)))
    begin : g_bad_cfg
        $fatal(1, "aes_encrypt_core: unsupported Nk/Nr pair");
    end

    typedef enum logic [0:0] {StIdle, StRun} st_e;

    st_e          st_q, st_d;
    logic [127:0] state_q, state_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         busy;

    logic [127:0] rk [Nr+1];
    logic [127:0] rk_sel;
    logic [127:0] sr_out;
    logic [127:0] full_out;
    logic [127:0] last_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a240 = a15;
        for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i sits at [127-8i]; row r of column c is byte r+4c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign rk[r] = allKeys[(Nr-r)*128 +: 128];
    end

    // round_q is 0 in idle, so the same mux supplies rk0 for the initial whitening.
    assign rk_sel   = rk[round_q];
    assign sr_out   = shift_rows(sub_bytes(state_q));
    assign full_out = mix_columns(sr_out) ^ rk_sel;
    assign last_out = sr_out ^ rk_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= StIdle;
            state_q <= '0;
            out_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            out_q   <= out_d;
            round_q <= round_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle: if (bus.start) st_d = StRun;
            StRun:  if (round_q == 4'(Nr)) st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = (st_q == StRun);
        state_d = state_q;
        out_d   = out_q;
        round_d = round_q;
        valid_d = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = bus.data ^ rk_sel;
                    round_d = 4'd1;
                end
            end
            StRun: begin
                if (round_q == 4'(Nr)) begin
                    out_d   = last_out;
                    valid_d = 1'b1;
                    round_d = 4'd0;
                end else begin
                    state_d = full_out;
                    round_d = round_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: one instance per key size, FIPS-197 vectors plus random blocks
// checked against a byte-array AES model with a log/antilog-generated S-box.
module tb_aes_encrypt_core;

    localparam logic [127:0] C1Pt   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1Ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2Ct   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3Ct   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ZeroCt = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] Key192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                       64'h0};
    localparam logic [255:0] Key256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk;
    logic reset;
    logic [1407:0] ak0;
    logic [1663:0] ak1;
    logic [1919:0] ak2;

    logic         st   [3];
    logic [127:0] dt   [3];
    logic [127:0] outs [3];
    logic         vld  [3];
    logic         bsy  [3];

    int checks;
    int failures;

    logic [7:0]  sbox_t [256];
    logic [31:0] w [60];

    aes_encrypt_core_if bus0 ();
    aes_encrypt_core_if bus1 ();
    aes_encrypt_core_if bus2 ();

    assign bus0.start = st[0];
    assign bus1.start = st[1];
    assign bus2.start = st[2];
    assign bus0.data  = dt[0];
    assign bus1.data  = dt[1];
    assign bus2.data  = dt[2];
    assign outs[0] = bus0.out;
    assign outs[1] = bus1.out;
    assign outs[2] = bus2.out;
    assign vld[0]  = bus0.valid;
    assign vld[1]  = bus1.valid;
    assign vld[2]  = bus2.valid;
    assign bsy[0]  = bus0.busy;
    assign bsy[1]  = bus1.busy;
    assign bsy[2]  = bus2.busy;

    aes_encrypt_core #(.Nk(4), .Nr(10)) u_dut128 (
        .clk(clk), .reset(reset), .allKeys(ak0), .bus(bus0)
    );
    aes_encrypt_core #(.Nk(6), .Nr(12)) u_dut192 (
        .clk(clk), .reset(reset), .allKeys(ak1), .bus(bus1)
    );
    aes_encrypt_core #(.Nk(8), .Nr(14)) u_dut256 (
        .clk(clk), .reset(reset), .allKeys(ak2), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse to build the S-box.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // Expand key into w[] and load the packed schedule onto instance k.
    task automatic set_key(input int k, input logic [255:0] key);
        int nk;
        int nr;
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] tmp;
        nk   = 4 + 2 * k;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        tmp = '0;
        for (int r = 0; r <= nr; r++) begin
            tmp[(nr+1-r)*128-1 -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        case (k)
            0:       ak0 = tmp[1407:0];
            1:       ak1 = tmp[1663:0];
            default: ak2 = tmp[1919:0];
        endcase
    endtask

    function automatic logic [7:0] rkb(input int rd, input int i);
        logic [31:0] wd;
        wd = w[4*rd + i/4];
        return wd[31-8*(i%4) -: 8];
    endfunction

    function automatic logic [127:0] model_enc(input int nr, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkb(0, i);
        for (int rd = 1; rd <= nr; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < nr) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb(rd, i);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // One-cycle start, then wait (bounded) for valid and check latency, result and pulse width.
    task automatic run_block(input int k, input logic [127:0] pt, input logic [127:0] exp,
                             input string tag);
        int n;
        st[k] = 1'b1;
        dt[k] = pt;
        tick();
        chk({tag, "_busy_hi"}, 128'(bsy[k]), 128'd1);
        st[k] = 1'b0;
        dt[k] = rnd128();
        n = 0;
        while (!vld[k] && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(10 + 2 * k));
        chk({tag, "_out"}, outs[k], exp);
        chk({tag, "_busy_lo"}, 128'(bsy[k]), 128'd0);
        tick();
        chk({tag, "_valid_pulse"}, 128'(vld[k]), 128'd0);
    endtask

    initial begin
        int n;
        int cnt;
        logic [255:0] key;
        logic [127:0] pt;
        checks   = 0;
        failures = 0;
        build_sbox();
        reset = 1'b1;
        ak0 = '0;
        ak1 = '0;
        ak2 = '0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            dt[k] = '0;
        end
        repeat (3) tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out%0d", k), outs[k], 128'd0);
            chk($sformatf("rst_valid%0d", k), 128'(vld[k]), 128'd0);
            chk($sformatf("rst_busy%0d", k), 128'(bsy[k]), 128'd0);
        end

        // FIPS-197 appendix C vectors.
        set_key(0, Key128);
        run_block(0, C1Pt, C1Ct, "fips128");
        set_key(1, Key192);
        run_block(1, C1Pt, C2Ct, "fips192");
        set_key(2, Key256);
        run_block(2, C1Pt, C3Ct, "fips256");

        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 3; t++) begin
                key = {rnd128(), rnd128()};
                pt  = rnd128();
                set_key(k, key);
                run_block(k, pt, model_enc(10 + 2 * k, pt), $sformatf("rand%0d_%0d", k, t));
            end
        end

        // Back-to-back with start held high, zero key.
        set_key(0, 256'h0);
        st[0] = 1'b1;
        dt[0] = C1Pt;
        tick();
        dt[0] = 128'h0;
        n = 0;
        while (!vld[0] && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_lat1", 128'(n), 128'd10);
        chk("b2b_out1", outs[0], model_enc(10, C1Pt));
        n = 1;
        tick();
        while (!vld[0] && n < 40) begin
            tick();
            n++;
        end
        st[0] = 1'b0;
        chk("b2b_gap", 128'(n), 128'd11);
        chk("b2b_out2", outs[0], ZeroCt);
        tick();
        chk("b2b_valid_end", 128'(vld[0]), 128'd0);
        chk("b2b_busy_end", 128'(bsy[0]), 128'd0);

        // A start pulse while busy is ignored.
        set_key(0, Key128);
        st[0] = 1'b1;
        dt[0] = C1Pt;
        tick();
        st[0] = 1'b0;
        repeat (3) tick();
        st[0] = 1'b1;
        dt[0] = rnd128();
        tick();
        st[0] = 1'b0;
        n = 4;
        while (!vld[0] && n < 40) begin
            tick();
            n++;
        end
        chk("ign_latency", 128'(n), 128'd10);
        chk("ign_out", outs[0], C1Ct);
        cnt = 0;
        repeat (15) begin
            tick();
            if (vld[0] || bsy[0]) cnt++;
        end
        chk("ign_no_extra", 128'(cnt), 128'd0);
        chk("ign_out_hold", outs[0], C1Ct);

        // Reset sampled at E5 aborts the block.
        st[0] = 1'b1;
        dt[0] = C1Pt;
        tick();
        st[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out", outs[0], 128'd0);
        chk("abort_valid", 128'(vld[0]), 128'd0);
        chk("abort_busy", 128'(bsy[0]), 128'd0);
        cnt = 0;
        repeat (20) begin
            tick();
            if (vld[0]) cnt++;
        end
        chk("abort_no_valid", 128'(cnt), 128'd0);
        run_block(0, C1Pt, C1Ct, "post_rst");

        // Idle hold: data toggles with start low.
        for (int i = 0; i < 6; i++) begin
            dt[0] = rnd128();
            tick();
            chk($sformatf("idle_out%0d", i), outs[0], C1Ct);
            chk($sformatf("idle_valid%0d", i), 128'(vld[0]), 128'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
